// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//
// Transmit-side byte buffer that sits directly in front of a UART transmitter.
// The host pushes bursts of bytes into a circular FIFO; a small drain FSM hands
// them to the UART one at a time, pacing on the UART's transmit-busy flag so
// the host never has to poll the UART per byte.
//
// Ports
//   clk         in   system clock
//   rst         in   synchronous reset, active high
//   wr_i        in   push strobe, one byte per cycle while high
//   dat_i       in   byte to push, sampled with wr_i
//   full        out  FIFO holds 2^ADDR_WIDTH entries
//   empty       out  FIFO holds no entries
//   level       out  current entry count, 0..2^ADDR_WIDTH
//   overflow    out  sticky, set by a push attempted while full (cleared by rst)
//   tx_pending  out  FIFO non-empty or drain FSM not idle
//   uart_wr     out  one-cycle write strobe to the UART
//   uart_dat    out  byte presented to the UART, held until the next pop
//   uart_busy   in   UART transmit-busy
//
// Drain FSM
//   state         | meaning
//   --------------+-----------------------------------------------------------
//   ST_IDLE       | UART free; pop and strobe as soon as a byte is queued
//   ST_WAIT_BUSY  | strobe issued; wait for the UART to raise busy (1-cycle lag)
//   ST_WAIT_IDLE  | UART transmitting; wait for busy to drop
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  tx_pending,
  output logic                  uart_wr,
  output logic [DATA_WIDTH-1:0] uart_dat,
  input  logic                  uart_busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [ADDR_WIDTH:0]   LVL_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   LVL_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = (ADDR_WIDTH)'(1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_IDLE = 2'd2
  } state_e;

  // Storage and state
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wptr_q,     wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q,     rptr_d;
  logic [ADDR_WIDTH:0]   level_q,    level_d;
  logic                  overflow_q, overflow_d;
  logic                  uart_wr_q,  uart_wr_d;
  logic [DATA_WIDTH-1:0] uart_dat_q, uart_dat_d;
  state_e                state_q,    state_d;

  logic full_w;
  logic empty_w;
  logic push;
  logic pop;

  // Status decode from the registered count. A push is always judged against
  // this registered full, so a pop in the same cycle never makes room for it.
  always_comb begin
    full_w  = (level_q == LVL_FULL);
    empty_w = (level_q == '0);
    push    = wr_i & ~full_w;
    pop     = (state_q == ST_IDLE) & ~empty_w & ~uart_busy;
  end

  // Drain FSM next-state and strobe generation
  always_comb begin
    state_d    = state_q;
    uart_wr_d  = 1'b0;
    uart_dat_d = uart_dat_q;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          uart_wr_d  = 1'b1;
          uart_dat_d = mem_q[rptr_q];
          state_d    = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        // The UART raises busy one cycle after the strobe; do not look for
        // its falling edge until it has been seen high.
        if (uart_busy) begin
          state_d = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (!uart_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pointer, level and overflow update
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;

    if (push) begin
      wptr_d = wptr_q + PTR_ONE;
    end
    if (pop) begin
      rptr_d = rptr_q + PTR_ONE;
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase

    if (wr_i && full_w) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      uart_wr_q  <= 1'b0;
      uart_dat_q <= '0;
      state_q    <= ST_IDLE;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      uart_wr_q  <= uart_wr_d;
      uart_dat_q <= uart_dat_d;
      state_q    <= state_d;
    end
  end

  // The data array has no reset; stale contents are unreachable once the
  // pointers and level are cleared.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wptr_q] <= dat_i;
    end
  end

  always_comb begin
    full       = full_w;
    empty      = empty_w;
    level      = level_q;
    overflow   = overflow_q;
    uart_wr    = uart_wr_q;
    uart_dat   = uart_dat_q;
    tx_pending = ~empty_w | (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_i = 1'b0;
  logic [DW-1:0] dat_i = '0;
  logic          uart_busy;
  logic          full, empty, overflow, tx_pending, uart_wr;
  logic [AW:0]   level;
  logic [DW-1:0] uart_dat;

  int total = 0;
  int bad   = 0;

  uart_tx_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_i       (wr_i),
    .dat_i      (dat_i),
    .full       (full),
    .empty      (empty),
    .level      (level),
    .overflow   (overflow),
    .tx_pending (tx_pending),
    .uart_wr    (uart_wr),
    .uart_dat   (uart_dat),
    .uart_busy  (uart_busy)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // UART busy model: either forced by the test, or automatic (busy rises the
  // cycle after a strobe and stays high for a frame of cur_f cycles).
  // -------------------------------------------------------------------------
  logic busy_force_en  = 1'b1;
  logic busy_force_val = 1'b0;
  logic auto_busy      = 1'b0;
  logic rand_frames    = 1'b0;
  int   busy_cnt       = 0;
  int   cur_f          = 10;

  assign uart_busy = busy_force_en ? busy_force_val : auto_busy;

  always @(negedge clk) begin
    if (busy_force_en) begin
      busy_cnt  = 0;
      auto_busy = 1'b0;
    end else begin
      if (uart_wr === 1'b1) begin
        cur_f    = rand_frames ? int'($urandom_range(1, 8)) : 10;
        busy_cnt = cur_f + 1;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end
      auto_busy = (busy_cnt > 0) && (busy_cnt <= cur_f);
    end
  end

  // -------------------------------------------------------------------------
  // Reference model: a byte queue plus the handshake rule "a byte is sent
  // whenever one is queued, the UART is not busy, and the previous byte's
  // busy period (rise then fall) has completed". Updated at each edge from
  // the inputs only; DUT outputs are compared on the falling edge.
  // -------------------------------------------------------------------------
  logic [DW-1:0] m_q[$];
  int            m_level = 0;
  logic          m_ovf   = 1'b0;
  int            m_hs    = 0;     // 0: free, 1: awaiting busy rise, 2: awaiting busy fall
  logic          m_send  = 1'b0;
  logic [DW-1:0] m_dat   = '0;
  logic          chk_on  = 1'b0;
  int            strobes = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_level = 0;
      m_ovf   = 1'b0;
      m_hs    = 0;
      m_send  = 1'b0;
      m_dat   = '0;
    end else begin
      m_send = (m_hs == 0) && !uart_busy && (m_level > 0);
      if (wr_i && m_level == DEPTH) m_ovf = 1'b1;
      if (m_send) begin
        m_dat = m_q.pop_front();
        m_level--;
      end
      if (wr_i && (m_level + (m_send ? 1 : 0)) < DEPTH) begin
        m_q.push_back(dat_i);
        m_level++;
      end
      if (m_send)                      m_hs = 1;
      else if (m_hs == 1 && uart_busy)  m_hs = 2;
      else if (m_hs == 2 && !uart_busy) m_hs = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_uart_wr",    uart_wr,    m_send);
      chk("m_uart_dat",   uart_dat,   m_dat);
      chk("m_level",      level,      m_level);
      chk("m_full",       full,       m_level == DEPTH);
      chk("m_empty",      empty,      m_level == 0);
      chk("m_overflow",   overflow,   m_ovf);
      chk("m_tx_pending", tx_pending, (m_level > 0) || (m_hs != 0));
      if (uart_wr === 1'b1) strobes++;
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers
  // -------------------------------------------------------------------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    wr_i = 1'b0;
    step();
    rst  = 1'b0;
  endtask

  task automatic push(input logic [DW-1:0] d);
    wr_i  = 1'b1;
    dat_i = d;
    step();
    wr_i  = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while (tx_pending && n < budget) begin
      step();
      n++;
    end
    chk(name, tx_pending, 1'b0);
  endtask

  // With busy forced: release busy until one strobe appears, then hold busy
  // high so the FSM settles in its wait-for-idle state.
  task automatic pop_one();
    int n = 0;
    busy_force_val = 1'b0;
    step();
    while (!uart_wr && n < 10) begin
      step();
      n++;
    end
    chk("pop_one_strobe", uart_wr, 1'b1);
    busy_force_val = 1'b1;
    step();
    step();
  endtask

  typedef struct {
    logic          rst;
    logic          wr;
    logic [DW-1:0] dat;
    int            lvl;
    logic          full;
    logic          empty;
    logic          ovf;
    logic          pend;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int max_lvl;
    logic saw_busy;

    vecs[0] = '{1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 8'hA1, 1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 8'hB2, 2, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 8'h00, 2, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 8'hC3, 3, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 8'hD4, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 8'h44, 1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 8'h00, 1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b0};

    // Reset, then idle with the UART free
    busy_force_en  = 1'b1;
    busy_force_val = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk_on = 1'b1;
    chk("rst_full",     full,       1'b0);
    chk("rst_empty",    empty,      1'b1);
    chk("rst_level",    level,      0);
    chk("rst_overflow", overflow,   1'b0);
    chk("rst_pending",  tx_pending, 1'b0);
    chk("rst_uart_wr",  uart_wr,    1'b0);
    chk("rst_uart_dat", uart_dat,   0);
    s0 = strobes;
    repeat (100) step();
    chk("idle_no_strobe", strobes - s0, 0);

    // Table vectors with the UART held busy so nothing drains
    busy_force_val = 1'b1;
    for (int i = 0; i < 9; i++) begin
      rst   = vecs[i].rst;
      wr_i  = vecs[i].wr;
      dat_i = vecs[i].dat;
      step();
      chk($sformatf("vec%0d_level", i),   level,      vecs[i].lvl);
      chk($sformatf("vec%0d_full", i),    full,       vecs[i].full);
      chk($sformatf("vec%0d_empty", i),   empty,      vecs[i].empty);
      chk($sformatf("vec%0d_ovf", i),     overflow,   vecs[i].ovf);
      chk($sformatf("vec%0d_pending", i), tx_pending, vecs[i].pend);
    end
    rst  = 1'b0;
    wr_i = 1'b0;

    // Single byte, automatic busy model
    busy_force_en = 1'b0;
    step();
    wr_i  = 1'b1;
    dat_i = 8'hA5;
    step();
    wr_i  = 1'b0;
    chk("single_no_early_strobe", uart_wr, 1'b0);
    step();
    chk("single_strobe", uart_wr, 1'b1);
    chk("single_dat", uart_dat, 8'hA5);
    saw_busy = 1'b0;
    for (int n = 0; n < 50 && tx_pending; n++) begin
      step();
      if (uart_busy) saw_busy = 1'b1;
    end
    chk("single_pending_fell", tx_pending, 1'b0);
    chk("single_busy_seen", saw_busy, 1'b1);
    chk("single_busy_low_at_done", uart_busy, 1'b0);

    // Burst of five consecutive bytes
    s0 = strobes;
    max_lvl = 0;
    for (int i = 1; i <= 5; i++) begin
      push(DW'(i));
      if (int'(level) > max_lvl) max_lvl = int'(level);
    end
    wait_drain(200, "burst_drain");
    step();
    chk("burst_max_level_ok", (max_lvl >= 4) && (max_lvl <= 5), 1'b1);
    chk("burst_strobes", strobes - s0, 5);

    // Fill to full plus one with busy held
    busy_force_en  = 1'b1;
    busy_force_val = 1'b1;
    do_reset();
    for (int i = 1; i <= 16; i++) push(DW'(8'h10 + i));
    chk("fill_full", full, 1'b1);
    chk("fill_level16", level, 16);
    chk("fill_no_ovf_yet", overflow, 1'b0);
    push(8'hEE);
    chk("fill_overflow", overflow, 1'b1);
    chk("fill_level_still16", level, 16);
    s0 = strobes;
    busy_force_en = 1'b0;
    wait_drain(400, "fill_drain");
    step();
    chk("fill_strobes", strobes - s0, 16);
    chk("fill_ovf_sticky", overflow, 1'b1);

    // Simultaneous push and pop at level 3 with the write pointer at 15
    busy_force_en  = 1'b1;
    busy_force_val = 1'b1;
    do_reset();
    for (int i = 0; i < 15; i++) push(DW'(8'h30 + i));
    for (int i = 0; i < 12; i++) pop_one();
    chk("simul_pre_level", level, 3);
    busy_force_val = 1'b0;
    step();
    chk("simul_pre_strobe", uart_wr, 1'b0);
    wr_i  = 1'b1;
    dat_i = 8'hE0;
    step();
    wr_i  = 1'b0;
    chk("simul_strobe", uart_wr, 1'b1);
    chk("simul_level", level, 3);
    busy_force_val = 1'b1;
    step();
    step();
    push(8'hE1);
    push(8'hE2);
    chk("wrap_level", level, 5);
    busy_force_en = 1'b0;
    wait_drain(200, "wrap_drain");

    // Reset while waiting for the UART with four bytes queued
    busy_force_en  = 1'b1;
    busy_force_val = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) push(DW'(8'h50 + i));
    pop_one();
    chk("midrst_pre_level", level, 4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_level", level, 0);
    chk("midrst_empty", empty, 1'b1);
    chk("midrst_pending", tx_pending, 1'b0);
    chk("midrst_uart_wr", uart_wr, 1'b0);
    busy_force_val = 1'b0;
    s0 = strobes;
    repeat (30) step();
    chk("midrst_no_strobe", strobes - s0, 0);

    // Randomized traffic against the reference model
    busy_force_en = 1'b0;
    rand_frames   = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      wr_i  = ($urandom_range(0, 99) < 45);
      dat_i = DW'($urandom);
      rst   = ($urandom_range(0, 499) == 0);
      step();
    end
    rst  = 1'b0;
    wr_i = 1'b0;
    wait_drain(500, "rand_drain");
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit-side byte buffer placed directly upstream of the UART transmitter. It accepts bursts of bytes from the host side into a circular FIFO. It then issues them one at a time to the UART's write strobe and data inputs, pacing on the UART's transmit-busy output. The host never has to poll the UART for each byte.

## Interface
- `ADDR_WIDTH`, default 4: FIFO depth is 2^ADDR_WIDTH entries (16).
- `DATA_WIDTH`, default 8: byte width. Must match the UART data input.

- `clk`, input, 1: system clock (50 MHz).
- `rst`, input, 1: reset, synchronous, active-high.
- `wr_i`, input, 1: push strobe; one byte per cycle while high.
- `dat_i`, input, DATA_WIDTH: byte to push; sampled when `wr_i` is high.
- `full`, output, 1: FIFO holds 2^ADDR_WIDTH entries.
- `empty`, output, 1: FIFO holds 0 entries.
- `level`, output, ADDR_WIDTH+1: current entry count, 0..2^ADDR_WIDTH.
- `overflow`, output, 1: sticky; set by a push attempted while full.
- `tx_pending`, output, 1: high while the FIFO is non-empty or the FSM is not in IDLE.
- `uart_wr`, output, 1: one-cycle write strobe to the UART.
- `uart_dat`, output, DATA_WIDTH: byte presented to the UART; held stable from the strobe until the next pop.
- `uart_busy`, input, 1: UART transmit-busy.

## Operation
- Storage: 2^ADDR_WIDTH × DATA_WIDTH register array.
- Read and write pointers are ADDR_WIDTH bits wide and wrap modulo depth.
- `level` is a separate counter of ADDR_WIDTH+1 bits.
- `full` = (level == depth); `empty` = (level == 0).
- Push: when `wr_i` & ~`full`, write `dat_i` at wptr and increment wptr.
- When `wr_i` & `full`: the data is dropped, pointers are unchanged, and `overflow` is set. `overflow` is cleared only by `rst`.
- A push is judged against the registered `full`. A pop in the same cycle does not make room for a push at full.
- Pop: `rdata[rptr]` is loaded into `uart_dat` and rptr increments.
- Level update:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged, and both pointers advance.
- Drain FSM, three states:
  - IDLE: if ~`empty` & ~`uart_busy`, then pop, set `uart_wr`=1 (registered) and go to WAIT_BUSY. Otherwise stay.
  - WAIT_BUSY: `uart_wr`=0. Stay until `uart_busy`=1, then go to WAIT_IDLE. This covers the UART's one-cycle lag between write and busy.
  - WAIT_IDLE: stay until `uart_busy`=0, then go to IDLE.
- The UART drops busy while the stop bit is still on the line. The next byte may be written at that point; the UART handles this.
- Reset mid-operation:
  - Pointers, level, `overflow` and FSM return to reset values on the next edge.
  - A byte already handed to the UART completes or aborts according to the UART's own reset.
  - Bytes still queued are discarded.

## Timing
- Reset values:
  - `full`=0, `empty`=1, `level`=0, `overflow`=0
  - `tx_pending`=0, `uart_wr`=0, `uart_dat`=0
  - FSM in IDLE, pointers 0.
- Latency with the FIFO empty and UART idle: a byte pushed at edge N appears with `uart_wr`=1 and `uart_dat`=byte in the cycle after edge N+1. That is 2 clocks from push to strobe.
- `uart_wr` is high for exactly one cycle per popped byte. It is never high on two consecutive cycles.
- Minimum spacing between strobes is 3 cycles (IDLE → WAIT_BUSY → WAIT_IDLE → IDLE). In practice spacing is governed by UART frame time: 10 bit periods.
- `level`, `full` and `empty` update on the edge after the push or pop.
- Pointer wrap: after 2^ADDR_WIDTH pushes, wptr returns to 0 with no discontinuity in data order.

## Test plan
- Reset, then idle: all outputs at reset values; `uart_wr` stays 0 for 100 cycles with `uart_busy`=0.
- Single byte: push 0xA5 with a busy model that rises 1 cycle after the strobe. Require:
  - `uart_wr` pulses 2 cycles after the push, with `uart_dat`=0xA5
  - `tx_pending` falls once busy drops.
- Burst of 5 (0x01..0x05) on consecutive cycles:
  - `level` reaches 4 or 5 and then drains.
  - Exactly 5 strobes occur, in order, each only after the prior busy falls.
  - Run against the real UART at 115200 baud, checking the serial line.
- Fill to full plus extra: with `uart_busy` held 1, push 17 bytes. Require:
  - `full`=1 and `level`=16 after 16 pushes
  - the 17th push sets `overflow`, with `level` still 16
  - after busy releases, bytes 1..16 emerge in order.
- Simultaneous push and pop at level 3: `level` stays 3. With wptr at 15, confirm wrap to 0 and correct ordering across the wrap.
- Reset during WAIT_IDLE with 4 bytes queued: the next cycle shows `level`=0, `empty`=1, FSM in IDLE, and no further `uart_wr`.
